// File: rtl/strx_framer.sv
// Frames an upstream byte stream: a fixed header, then a pass-through body while reply stays high.
// Define STRX_CHKSUM_EN to append a one-byte modulo-256 body checksum after each body.
module strx_framer #(
    parameter int          PTRWIDTH  = 12,
    parameter int          HDR_LEN   = 4,
    parameter logic [63:0] HDR       = 64'h0000_0000_7600_25EB,
    parameter int          MARGIN    = 300,
    parameter logic [2:0]  ST_ACCEPT = 3'b001
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PTRWIDTH:0]   uw,
    input  logic [2:0]          st,
    input  logic                reply,
    input  logic                wen,
    input  logic [7:0]          din,
    input  logic                ready,
    output logic                valid,
    output logic [7:0]          dout,
    output logic                busy,
    output logic                drop,
    output logic                ovf
);
    localparam int unsigned START_LIMIT = (1 << PTRWIDTH) - MARGIN;

`ifdef STRX_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_e;
`else
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;
`endif

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        reply_dly_q, reply_dly_d;
    logic        armed_q, armed_d;
    logic        drop_q, drop_d;
    logic        ovf_q, ovf_d;
    logic        pos;
    logic        start_ok;
`ifdef STRX_CHKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    // armed_q blocks a reply that is already high when reset releases from looking like a fresh edge
    assign pos      = reply && !reply_dly_q && armed_q;
    assign start_ok = (st == ST_ACCEPT) && (32'(uw) < START_LIMIT);
    assign busy     = (state_q != IDLE);
    assign drop     = drop_q;
    assign ovf      = ovf_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        reply_dly_d = reply;
        armed_d     = armed_q || !reply;
        drop_d      = 1'b0;
        ovf_d       = ovf_q;
`ifdef STRX_CHKSUM_EN
        sum_d       = sum_q;
`endif
        valid       = 1'b0;
        dout        = 8'h00;

        case (state_q)
            IDLE: begin
                if (pos) begin
                    if (start_ok) begin
                        state_d = HEAD;
                        idx_d   = 3'd0;
                        ovf_d   = 1'b0;
`ifdef STRX_CHKSUM_EN
                        sum_d   = 8'h00;
`endif
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
            end
            HEAD: begin
                valid = 1'b1;
                dout  = HDR[{idx_q, 3'b000} +: 8];
                if (ready) begin
                    if (idx_q == 3'(HDR_LEN - 1)) begin
                        state_d = BODY;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            BODY: begin
                valid = wen;
                dout  = din;
                if (wen && !ready)
                    ovf_d = 1'b1;
`ifdef STRX_CHKSUM_EN
                if (wen && ready)
                    sum_d = sum_q + din;
                if (!reply)
                    state_d = TAIL;
`else
                if (!reply)
                    state_d = IDLE;
`endif
            end
`ifdef STRX_CHKSUM_EN
            TAIL: begin
                valid = 1'b1;
                dout  = sum_q;
                if (ready)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            reply_dly_q <= 1'b0;
            armed_q     <= 1'b0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef STRX_CHKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            reply_dly_q <= reply_dly_d;
            armed_q     <= armed_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
`ifdef STRX_CHKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_strx_framer.sv
// Self-checking bench for strx_framer: randomized frames checked against a transfer-level stream model.
`timescale 1ns/1ps
module tb_strx_framer;
    localparam int PTRWIDTH = 12;
    localparam int HDR_LEN  = 4;
    localparam int LIMIT    = (1 << PTRWIDTH) - 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PTRWIDTH:0] uw;
    logic [2:0]        st;
    logic              reply, wen, ready;
    logic [7:0]        din;
    logic              valid, busy, drop, ovf;
    logic [7:0]        dout;

    int checks = 0;
    int errors = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    bit drop_seen;
    byte unsigned hdr_b[4] = '{8'hEB, 8'h25, 8'h00, 8'h76};
    bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    strx_framer dut (
        .clk(clk), .rst_n(rst_n), .uw(uw), .st(st), .reply(reply), .wen(wen),
        .din(din), .ready(ready), .valid(valid), .dout(dout), .busy(busy),
        .drop(drop), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && valid && ready) got_q.push_back(dout);
        if (drop) drop_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
    endtask

    task automatic start_stream();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(hdr_b[i]);
    endtask

    // mode 0 random, 1 body 01,02,03 all accepted, 2 body stalled (ovf), 3 header ready pattern 1,0,1,1,0,1
    task automatic frame(input int mode, input int hdr_pct, input int body_len,
                         input int body_pct, input logic [PTRWIDTH:0] uw_v);
        int n;
        int cyc;
        byte unsigned s;
        bit ovf_exp;
        bit r;
        s = 0;
        ovf_exp = 0;
        reply = 0; wen = 0; ready = 1; st = 3'b001; uw = uw_v;
        tick();
        start_stream();
        reply = 1;
        tick();
        drop_seen = 0;
        check("start_busy", busy, 1'b1);
        check("start_ovf_clear", ovf, 1'b0);
        n = 0;
        cyc = 0;
        while (n < HDR_LEN && cyc < 100) begin
            if (mode == 3) ready = pat[cyc % 6];
            else ready = ($urandom_range(0, 99) < hdr_pct);
            wen = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            if (ready) n++;
            tick();
            cyc++;
        end
        for (int i = 0; i <= body_len; i++) begin
            reply = (i < body_len);
            case (mode)
                1: begin wen = (i < body_len); din = 8'(i + 1); ready = 1; end
                2: begin wen = 1; din = 8'($urandom); ready = 0; end
                default: begin
                    wen = 1'($urandom_range(0, 1));
                    din = 8'($urandom);
                    ready = ($urandom_range(0, 99) < body_pct);
                end
            endcase
            if (wen && ready) begin exp_q.push_back(din); s = s + din; end
            if (wen && !ready) ovf_exp = 1;
            tick();
        end
        wen = 0;
        reply = 0;
`ifdef STRX_CHKSUM_EN
        exp_q.push_back(s);
        r = 0;
        cyc = 0;
        while (!r && cyc < 50) begin
            r = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            ready = r;
            tick();
            cyc++;
        end
`else
        r = 0;
`endif
        ready = 1;
        tick();
        check("end_busy", busy, 1'b0);
        check("ovf_sticky", ovf, ovf_exp);
        check("no_drop_in_frame", drop_seen, 1'b0);
        compare_stream($sformatf("frame_m%0d", mode));
        if (mode == 1) begin
`ifdef STRX_CHKSUM_EN
            check("tail_sum", (got_q.size() > 0) ? 32'(got_q[got_q.size() - 1]) : 32'hFFFF_FFFF, 32'h06);
`else
            check("last_body", (got_q.size() > 0) ? 32'(got_q[got_q.size() - 1]) : 32'hFFFF_FFFF, 32'h03);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; uw = 100; st = 3'b001; reply = 0; wen = 0; ready = 1; din = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_dout", dout, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1;
        tick();

        frame(1, 100, 3, 100, 100);
        frame(3, 100, 2, 100, 100);

        // rejection at the free-space boundary and on a wrong status code
        reply = 0; st = 3'b001; uw = LIMIT; tick();
        reply = 1; tick();
        check("drop_at_limit", drop, 1'b1);
        check("drop_not_busy", busy, 1'b0);
        #4;
        check("drop_valid_low", valid, 1'b0);
        tick();
        check("drop_one_cycle", drop, 1'b0);
        reply = 0; st = 3'b010; uw = 100; tick();
        reply = 1; tick();
        check("drop_bad_st", drop, 1'b1);
        check("drop_bad_st_busy", busy, 1'b0);
        frame(0, 100, 2, 100, 13'(LIMIT - 1));

        // ovf set by a stalled body byte, cleared by the following start
        frame(2, 100, 3, 100, 100);
        frame(0, 100, 2, 100, 100);

        // reply pulse shorter than the header, with a re-rise while busy
        reply = 0; ready = 1; wen = 0; uw = 100; st = 3'b001; tick();
        start_stream();
        reply = 1; tick();
        drop_seen = 0;
        reply = 0; tick();
        reply = 1; tick();
        reply = 0;
        repeat (6) tick();
`ifdef STRX_CHKSUM_EN
        exp_q.push_back(8'h00);
`endif
        check("short_busy_end", busy, 1'b0);
        check("short_no_drop", drop_seen, 1'b0);
        compare_stream("short");

        // asynchronous reset while header byte 2 is presented
        reply = 0; ready = 1; wen = 0; tick();
        reply = 1; tick();
        tick();
        tick();
        #2;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 0;
        #1;
        check("async_rst_valid", valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_dout", dout, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_idle%0d", i), {busy, valid}, 2'b00);
        end
        frame(0, 100, 3, 100, 100);

        for (int k = 0; k < 15; k++)
            frame(0, $urandom_range(30, 100), $urandom_range(0, 8),
                  $urandom_range(30, 100), 13'($urandom_range(0, LIMIT - 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
